// File: rtl/mul_booth_param.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// mul_booth_param
//
// Sequential radix-4 Booth multiplier. The operands are captured as the block
// leaves LOAD. Each EXEC cycle then retires one Booth digit, so a product takes
// N = WIDTH/2 + 1 EXEC cycles. The product stays in `result` while the block
// sits in DONE, and op_clear returns it to IDLE.
//
// Optional feature (macro MUL_BOOTH_EARLY_TERM_EN):
//   When the macro is defined, EXEC ends as soon as every remaining Booth digit
//   would decode to zero.
//
// Parameters:
//   WIDTH        operand width in bits (even, >= 4)
//
// Ports:
//   clk          clock, rising-edge active
//   reset_n      synchronous active-low reset
//   op_start     start request (accepted in IDLE only)
//   op_clear     abort / clear request (accepted in every state)
//   op_signed    1 = two's-complement operands, 0 = unsigned
//   multiplicand operand A
//   multiplier   operand B
//   result       2*WIDTH-bit product register (valid while done = 1)
//   state        current state: IDLE=00, DONE=01, LOAD=10, EXEC=11
//   done         high in DONE
//   busy         high in LOAD or EXEC
// -----------------------------------------------------------------------------
module mul_booth_param #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           state,
    output logic                 done,
    output logic                 busy
);

    localparam int N     = WIDTH / 2 + 1;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] DONE = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] EXEC = 2'b11;

    logic [CNT_W-1:0]   cnt;
    // Multiplicand, already extended to the accumulator width. It is shifted
    // left by two bits every iteration, which supplies the 4^i weight.
    logic [2*WIDTH-1:0] mcand;
    // Extended multiplier with a 0 appended below bit 0. It is shifted right
    // arithmetically by two bits every iteration, so the current triple is
    // always bits [2:0].
    logic [WIDTH+2:0]   mplier;

    logic               term_sel;
    logic               term_dbl;
    logic               term_neg;
    logic [2*WIDTH-1:0] magnitude;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic               last_iter;

    // Booth digit decode of {b[2i+1], b[2i], b[2i-1]}.
    // NOTE: every signal an always_comb block writes gets a default first, so
    // that no path through the case can leave a latch behind.
    always_comb begin
        term_sel = 1'b0;
        term_dbl = 1'b0;
        term_neg = 1'b0;
        case (mplier[2:0])
            3'b001, 3'b010: term_sel = 1'b1;
            3'b011:         begin term_sel = 1'b1; term_dbl = 1'b1; end
            3'b100:         begin term_sel = 1'b1; term_dbl = 1'b1; term_neg = 1'b1; end
            3'b101, 3'b110: begin term_sel = 1'b1; term_neg = 1'b1; end
            default:        ;
        endcase
    end

    // A negative digit becomes the one's complement of the term plus a carry-in
    // of 1 on the same adder. Carries out of bit 2*WIDTH-1 are dropped.
    always_comb begin
        magnitude = '0;
        if (term_sel) begin
            magnitude = term_dbl ? (mcand << 1) : mcand;
        end
        addend = term_neg ? ~magnitude : magnitude;
        sum    = result + addend + {{(2*WIDTH-1){1'b0}}, term_neg};
    end

`ifdef MUL_BOOTH_EARLY_TERM_EN
    // The remaining digits are all zero once the bits from the current top of
    // the triple upward are uniform (all 0s or all 1s).
    always_comb begin
        last_iter = (cnt == LAST_ITER) || (&mplier[WIDTH+2:2]) || ~(|mplier[WIDTH+2:2]);
    end
`else
    always_comb begin
        last_iter = (cnt == LAST_ITER);
    end
`endif

    // NOTE: all state uses non-blocking assignments, so each register reads the
    // values from before the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            result <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (op_clear) begin
            state  <= IDLE;
            result <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    result <= '0;
                    if (op_start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    mcand  <= {{WIDTH{op_signed & multiplicand[WIDTH-1]}}, multiplicand};
                    mplier <= {{2{op_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};
                    result <= '0;
                    cnt    <= '0;
                    state  <= EXEC;
                end
                EXEC: begin
                    result <= sum;
                    mcand  <= mcand << 2;
                    mplier <= {{2{mplier[WIDTH+2]}}, mplier[WIDTH+2:2]};
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                default: ; // DONE: hold result until op_clear
            endcase
        end
    end

    always_comb begin
        done = (state == DONE);
        busy = state[1];
    end

endmodule

// File: tb/tb_mul_booth_param.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_mul_booth_param
//
// Self-checking bench for mul_booth_param with WIDTH = 64. The expected
// products come from plain 128-bit arithmetic on the extended operands. The
// expected EXEC length comes from the zero-digit rule when
// MUL_BOOTH_EARLY_TERM_EN is defined. Without the macro it is always N.
// -----------------------------------------------------------------------------
module tb_mul_booth_param;

    localparam int W = 64;
    localparam int N = W / 2 + 1;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           op_start;
    logic           op_clear;
    logic           op_signed;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic [2*W-1:0] result;
    logic [1:0]     state;
    logic           done;
    logic           busy;

    int tests  = 0;
    int failed = 0;

    mul_booth_param #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .op_signed    (op_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .state        (state),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference product: extend both operands to 128 bits, then multiply.
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b, input bit s);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = s ? {{64{a[63]}}, a} : {64'b0, a};
        eb = s ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    // Expected number of EXEC cycles for a given multiplier.
    function automatic int exp_exec(input logic [63:0] b, input bit s);
`ifdef MUL_BOOTH_EARLY_TERM_EN
        // bx[k] holds extended multiplier bit b[k-1]; bx[0] is the appended 0.
        logic [66:0] bx;
        logic        top;
        bit          same;
        bx = {s & b[63], s & b[63], b, 1'b0};
        for (int i = 0; i < N; i++) begin
            top  = bx[2*i+2];
            same = 1'b1;
            for (int j = 2*i + 3; j <= 66; j++) begin
                if (bx[j] !== top) same = 1'b0;
            end
            if (same) return i + 1;
        end
        return N;
`else
        if (s && b[63]) return N;
        return N;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op(input string tag);
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check({tag, "_clr_state"}, state, 2'b00);
        check({tag, "_clr_result"}, result, 128'd0);
    endtask

    // One full operation. Leaves the DUT in DONE.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input bit s, input logic [127:0] exp_res);
        int edges;
        int exec_cnt;
        int want;
        want         = exp_exec(b, s);
        multiplicand = a;
        multiplier   = b;
        op_signed    = s;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        edges    = 1;
        exec_cnt = 0;
        check({tag, "_load"}, state, 2'b10);
        while (!done && edges < 200) begin
            tick();
            edges++;
            // Once EXEC is running, the inputs must no longer matter.
            if (edges == 2) begin
                multiplicand = ~a;
                multiplier   = ~b;
                op_signed    = ~s;
            end
            if (state == 2'b11) exec_cnt++;
        end
        check({tag, "_latency"}, edges, want + 2);
        check({tag, "_exec_cycles"}, exec_cnt, want);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_state"}, state, 2'b01);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [63:0]  ra;
        logic [63:0]  rb;
        logic [127:0] held;
        bit           rs;

        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        op_signed    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        check("rst_state", state, 2'b00);
        check("rst_result", result, 128'd0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick();
        check("idle_result", result, 128'd0);

        run_op("u3x5", 64'd3, 64'd5, 1'b0, 128'd15);
        clear_op("u3x5");

        run_op("s_m1xm1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1);
        clear_op("s_m1xm1");

        run_op("s_minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
               128'h4000_0000_0000_0000_0000_0000_0000_0000);
        clear_op("s_minxmin");

        run_op("u_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // op_start held in DONE must not restart the operation.
        held     = result;
        op_start = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        op_start = 1'b0;
        check("done_hold_state", state, 2'b01);
        check("done_hold_result", result, held);
        clear_op("u_ones");

        // Abort with op_clear in the 10th EXEC cycle, then a fresh operation.
        multiplicand = 64'h1234_5678_9ABC_DEF0;
        multiplier   = 64'hFEDC_BA98_7654_3210;
        op_signed    = 1'b1;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("abort_in_exec", state, 2'b11);
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check("abort_state", state, 2'b00);
        check("abort_result", result, 128'd0);
        run_op("u7x6", 64'd7, 64'd6, 1'b0, 128'd42);
        clear_op("u7x6");

        // Reset during EXEC overrides op_start.
        multiplicand = 64'hDEAD_BEEF_0000_1111;
        multiplier   = 64'h0F0F_0F0F_F0F0_F0F0;
        op_signed    = 1'b0;
        op_start     = 1'b1;
        tick();
        tick();
        tick();
        check("rst_exec_pre", busy, 1'b1);
        reset_n = 1'b0;
        tick();
        check("rst_exec_state", state, 2'b00);
        check("rst_exec_result", result, 128'd0);
        check("rst_exec_busy", busy, 1'b0);
        tick();
        check("rst_over_start", state, 2'b00);
        op_start = 1'b0;
        reset_n  = 1'b1;
        tick();

        // Early-termination candidates.
        run_op("u9x3", 64'd9, 64'd3, 1'b0, 128'd27);
        clear_op("u9x3");
        run_op("u9x0", 64'd9, 64'd0, 1'b0, 128'd0);
        clear_op("u9x0");

        // Randomised operands against the arithmetic model.
        for (int k = 0; k < 30; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 5 == 1) rb = rb >> $urandom_range(0, 63);
            if (k % 7 == 2) ra = 64'h8000_0000_0000_0000;
            if (k % 7 == 3) rb = 64'hFFFF_FFFF_FFFF_FFFF;
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", k), ra, rb, rs, model(ra, rb, rs));
            clear_op($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mul_booth_param.md
MUL_BOOTH_PARAM -- requirements
Module: mul_booth_param

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port op_start  input  1  start request; honoured only in IDLE.
REQ-005 SHALL have port op_clear  input  1  abort/clear request; honoured in every state.
REQ-006 SHALL have port op_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port multiplicand  input  WIDTH  operand A.
REQ-008 SHALL have port multiplier  input  WIDTH  operand B.
REQ-009 SHALL have port result  output  2*WIDTH  product register.
REQ-010 SHALL have port state  output  2  current FSM state.
REQ-011 SHALL have port done  output  1  high exactly when state is DONE.
REQ-012 SHALL have port busy  output  1  high when state is LOAD or EXEC.

Function
REQ-013 SHALL encode states IDLE=2'b00, DONE=2'b01, LOAD=2'b10, EXEC=2'b11.
REQ-014 SHALL give op_clear priority over all other inputs: op_clear=1 -> next state IDLE, result cleared to 0, iteration counter cleared.
REQ-015 SHALL transition IDLE -> LOAD when op_start=1; otherwise remain in IDLE with result=0.
REQ-016 SHALL spend exactly one cycle in LOAD; at the edge leaving LOAD, multiplicand, multiplier and op_signed are captured, and result is cleared.
REQ-017 SHALL extend both captured operands to WIDTH+2 bits (sign-extended if op_signed=1, zero-extended if 0) and append a 0 below multiplier bit 0.
REQ-018 SHALL, in each EXEC cycle i (i=0..N-1, N=WIDTH/2+1), decode the radix-4 Booth triple {b[2i+1],b[2i],b[2i-1]} into one of 0, +A, +2A, -A, -2A, add the term (weighted by 4^i) into the 2*WIDTH-bit accumulator, and discard carries beyond 2*WIDTH bits.
REQ-019 SHALL form negative terms as one's complement plus carry-in on the adder, not as a separate negation stage.
REQ-020 SHALL transition EXEC -> DONE after iteration N-1 (subject to REQ-026); total latency from op_start sampled in IDLE to done=1 is N+2 edges.
REQ-021 SHALL hold result and remain in DONE until op_clear=1; op_start in DONE, LOAD or EXEC is ignored.
REQ-022 SHALL treat result as don't-care in LOAD and EXEC; it is valid only while done=1.
REQ-023 SHALL produce the exact product for all operand values, including signed most-negative x most-negative and unsigned all-ones x all-ones.
REQ-024 SHALL abort when op_clear arrives mid-EXEC; the next op_start begins a fresh operation with no residue.

Reset
REQ-025 SHALL, on reset_n=0 at a clk edge, set state=IDLE, result=0, done=0, busy=0, clear the counter and operand registers; reset overrides op_clear and op_start.

Configuration
REQ-026 SHALL, with macro MUL_BOOTH_EARLY_TERM_EN defined, leave EXEC for DONE after iteration i whenever all extended multiplier bits above 2i+1 equal b[2i+1] (remaining triples all decode to 0); without the macro, EXEC always lasts exactly N cycles.

Verification
REQ-027 SHALL cover: WIDTH=64, unsigned, A=3, B=5 -> result=15, done on edge 35 (without macro).
REQ-028 SHALL cover: WIDTH=64, signed, A=-1, B=-1 -> result=1; A=0x8000_0000_0000_0000, B=same -> result=2^126.
REQ-029 SHALL cover: WIDTH=64, unsigned, A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-030 SHALL cover: op_clear pulsed during 10th EXEC cycle -> IDLE next edge, result=0; new op A=7, B=6 -> result=42.
REQ-031 SHALL cover: reset_n=0 in EXEC -> state=00, result=0, busy=0 at next edge; op_start held in DONE -> no restart.
REQ-032 SHALL cover: MUL_BOOTH_EARLY_TERM_EN defined, unsigned, B=3, A=9 -> exactly 2 EXEC cycles, result=27; B=0 -> 1 EXEC cycle, result=0.
